mau_load_swc: RTL and testbench

Memory-access-unit load engine; the receiving end of the execute stage's load request bus (`exu_load_*`). It latches a request on the rising edge of `exu_load_en`, performs one AHB-Lite single read at base + offset, extracts and sign- or zero-extends the addressed byte/halfword/word, and writes the result to the register file. It sits between the execute stage, the core's AHB master port and regfile write port 1, and reports busy, done and error back to the pipeline.

---
 rtl/mau_load_swc_pkg.sv | 43 ++++
 rtl/mau_load_swc_extend.sv | 26 ++
 rtl/mau_load_swc.sv | 106 ++++++++++
 tb/tb_mau_load_swc.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mau_load_swc_pkg.sv
// Shared core definitions for the load path: size codes, AHB encodings,
// load FSM state encoding and the latched request record.
package mau_load_swc_pkg;

  localparam logic [1:0] LOAD_IDLE     = 2'd0;
  localparam logic [1:0] LOAD_BYTE     = 2'd1;
  localparam logic [1:0] LOAD_HALFWORD = 2'd2;
  localparam logic [1:0] LOAD_WORD     = 2'd3;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ADDR = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_WB   = 3'd3;
  localparam logic [2:0] ST_ERR  = 3'd4;

  typedef struct packed {
    logic [4:0]  rd;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
  } load_req_t;

  function automatic logic [2:0] load_hsize(input logic [1:0] size);
    case (size)
      LOAD_HALFWORD: load_hsize = HSIZE_HALF;
      LOAD_WORD:     load_hsize = HSIZE_WORD;
      default:       load_hsize = HSIZE_BYTE;
    endcase
  endfunction

  function automatic logic load_misaligned(input logic [1:0] size, input logic [1:0] lsb);
    load_misaligned = ((size == LOAD_HALFWORD) && lsb[0]) ||
                      ((size == LOAD_WORD) && (lsb != 2'b00));
  endfunction

endpackage

// File: rtl/mau_load_swc_extend.sv
// Lane select of the addressed byte/halfword from the little-endian read bus,
// followed by sign or zero extension to 32 bits.
module mau_load_extend
  import mau_load_swc_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic [1:0]  addr_lsb,
  input  logic [31:0] hrdata,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = hrdata[{addr_lsb, 3'b000} +: 8];
    half_sel = addr_lsb[1] ? hrdata[31:16] : hrdata[15:0];
    case (size)
      LOAD_BYTE:     data = {{24{sext & byte_sel[7]}}, byte_sel};
      LOAD_HALFWORD: data = {{16{sext & half_sel[15]}}, half_sel};
      default:       data = hrdata;
    endcase
  end

endmodule

// File: rtl/mau_load_swc.sv
// Load engine: edge-detects execute-stage requests, runs one AHB-Lite single
// read and writes the extended result to regfile port 1.
module mau_load_swc
  import mau_load_swc_pkg::*;
(
  input  logic        hclk,
  input  logic        hrstn,
  input  logic        exu_load_en,
  input  logic [4:0]  exu_load_rd,
  input  logic [31:0] exu_load_base_addr,
  input  logic [31:0] exu_load_offset,
  input  logic        exu_load_sext,
  input  logic [1:0]  exu_load_size,
  output logic [31:0] haddr,
  output logic [1:0]  htrans,
  output logic        hwrite,
  output logic [2:0]  hsize,
  input  logic        hready,
  input  logic        hresp,
  input  logic [31:0] hrdata,
  output logic [4:0]  reg_waddr_1,
  output logic        reg_wen_1,
  output logic [31:0] reg_wdata_1,
  output logic        mau_load_busy,
  output logic        mau_load_done,
  output logic        mau_load_err
);

  logic        en_prev_q;
  logic [2:0]  state_q, state_d;
  load_req_t   req_q, req_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] addr_sum;
  logic [31:0] ext_data;
  logic        accept;

  assign addr_sum = exu_load_base_addr + exu_load_offset;
  assign accept   = (state_q == ST_IDLE) && exu_load_en && !en_prev_q &&
                    (exu_load_size != LOAD_IDLE);

  mau_load_extend u_extend (
    .size     (req_q.size),
    .sext     (req_q.sext),
    .addr_lsb (req_q.addr[1:0]),
    .hrdata   (hrdata),
    .data     (ext_data)
  );

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          req_d.rd   = exu_load_rd;
          req_d.size = exu_load_size;
          req_d.sext = exu_load_sext;
          req_d.addr = addr_sum;
          // Misaligned requests never reach the bus.
          state_d = load_misaligned(exu_load_size, addr_sum[1:0]) ? ST_ERR : ST_ADDR;
        end
      end
      ST_ADDR: if (hready) state_d = ST_DATA;
      ST_DATA: begin
        if (hready) begin
          if (hresp) begin
            state_d = ST_ERR;
          end else begin
            wdata_d = ext_data;
            state_d = ST_WB;
          end
        end
      end
      ST_WB:   state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge hclk or negedge hrstn) begin
    if (!hrstn) begin
      en_prev_q <= 1'b0;
      state_q   <= ST_IDLE;
      req_q     <= '0;
      wdata_q   <= '0;
    end else begin
      en_prev_q <= exu_load_en;
      state_q   <= state_d;
      req_q     <= req_d;
      wdata_q   <= wdata_d;
    end
  end

  assign haddr         = req_q.addr;
  assign htrans        = (state_q == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign hwrite        = 1'b0;
  assign hsize         = load_hsize(req_q.size);
  assign reg_waddr_1   = req_q.rd;
  assign reg_wen_1     = (state_q == ST_WB) && (req_q.rd != 5'd0);
  assign reg_wdata_1   = wdata_q;
  assign mau_load_busy = (state_q != ST_IDLE);
  assign mau_load_done = (state_q == ST_WB) || (state_q == ST_ERR);
  assign mau_load_err  = (state_q == ST_ERR);

endmodule

// File: tb/tb_mau_load_swc.sv
// Bench for mau_load_swc: directed vector table, hand sequences and random
// loads against a behavioural AHB slave plus load-result model.
module tb_mau_load_swc;

  logic        hclk = 1'b0;
  logic        hrstn;
  logic        exu_load_en;
  logic [4:0]  exu_load_rd;
  logic [31:0] exu_load_base_addr;
  logic [31:0] exu_load_offset;
  logic        exu_load_sext;
  logic [1:0]  exu_load_size;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic        hready;
  logic        hresp;
  logic [31:0] hrdata;
  logic [4:0]  reg_waddr_1;
  logic        reg_wen_1;
  logic [31:0] reg_wdata_1;
  logic        mau_load_busy;
  logic        mau_load_done;
  logic        mau_load_err;

  int checks   = 0;
  int failures = 0;

  always #5 hclk = ~hclk;

  mau_load_swc dut (
    .hclk               (hclk),
    .hrstn              (hrstn),
    .exu_load_en        (exu_load_en),
    .exu_load_rd        (exu_load_rd),
    .exu_load_base_addr (exu_load_base_addr),
    .exu_load_offset    (exu_load_offset),
    .exu_load_sext      (exu_load_sext),
    .exu_load_size      (exu_load_size),
    .haddr              (haddr),
    .htrans             (htrans),
    .hwrite             (hwrite),
    .hsize              (hsize),
    .hready             (hready),
    .hresp              (hresp),
    .hrdata             (hrdata),
    .reg_waddr_1        (reg_waddr_1),
    .reg_wen_1          (reg_wen_1),
    .reg_wdata_1        (reg_wdata_1),
    .mau_load_busy      (mau_load_busy),
    .mau_load_done      (mau_load_done),
    .mau_load_err       (mau_load_err)
  );

  typedef struct {
    string       name;
    logic [31:0] base;
    logic [31:0] off;
    logic [4:0]  rd;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] data;
    int          awaits;
    int          dwaits;
    logic        rerr;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: shift the addressed field down, mask to width, then extend.
  function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [1:0] size,
                                           input logic sext, input logic [31:0] data);
    int unsigned shift, width;
    logic [31:0] mask, v;
    width = (size == 2'd1) ? 8 : (size == 2'd2) ? 16 : 32;
    shift = (size == 2'd1) ? (addr % 4) * 8 : (size == 2'd2) ? ((addr / 2) % 2) * 16 : 0;
    mask  = (width == 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    v     = (data >> shift) & mask;
    if (sext && v[width-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic ref_misaligned(input logic [31:0] addr, input logic [1:0] size);
    return ((size == 2'd2) && (addr % 2 != 0)) || ((size == 2'd3) && (addr % 4 != 0));
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " haddr"}, haddr, 32'h0);
    chk({tag, " htrans"}, {30'h0, htrans}, 32'h0);
    chk({tag, " hsize"}, {29'h0, hsize}, 32'h0);
    chk({tag, " hwrite"}, {31'h0, hwrite}, 32'h0);
    chk({tag, " waddr"}, {27'h0, reg_waddr_1}, 32'h0);
    chk({tag, " wen"}, {31'h0, reg_wen_1}, 32'h0);
    chk({tag, " wdata"}, reg_wdata_1, 32'h0);
    chk({tag, " busy/done/err"}, {29'h0, mau_load_busy, mau_load_done, mau_load_err}, 32'h0);
  endtask

  // Called #1 after a rising edge; holds exu_load_en high across the whole load.
  task automatic run_load(input vec_t v);
    logic [31:0] addr;
    logic        mis, nonseq_now, dpend, err_seen;
    logic [31:0] haddr_seen, wdata_seen;
    logic [2:0]  hsize_seen;
    logic [4:0]  waddr_seen;
    int          xfers, done_cyc, wen_cnt, aw, dw, exp_cyc, exp_wen;
    addr = v.base + v.off;
    mis  = ref_misaligned(addr, v.size);
    xfers = 0; done_cyc = -1; wen_cnt = 0; aw = v.awaits; dw = v.dwaits;
    dpend = 1'b0; err_seen = 1'b0; haddr_seen = '0; hsize_seen = '0;
    wdata_seen = '0; waddr_seen = '0;
    exu_load_en = 1'b1; exu_load_rd = v.rd; exu_load_base_addr = v.base;
    exu_load_offset = v.off; exu_load_sext = v.sext; exu_load_size = v.size;
    hready = 1'b1; hresp = 1'b0;
    @(posedge hclk); #1;
    chk({v.name, " busy after accept"}, {31'h0, mau_load_busy}, 32'h1);
    for (int c = 0; c < 40 && done_cyc < 0; c++) begin
      nonseq_now = (htrans == 2'b10);
      if (nonseq_now) begin haddr_seen = haddr; hsize_seen = hsize; end
      if (reg_wen_1) begin wen_cnt++; wdata_seen = reg_wdata_1; waddr_seen = reg_waddr_1; end
      if (mau_load_done) begin done_cyc = c; err_seen = mau_load_err; end
      if (dpend) begin
        hresp = v.rerr;
        if (dw > 0) begin hready = 1'b0; dw--; hrdata = $urandom; end
        else begin hready = 1'b1; hrdata = v.data; end
      end else if (nonseq_now && aw > 0) begin
        hready = 1'b0; hresp = 1'b0; aw--; hrdata = $urandom;
      end else begin
        hready = 1'b1; hresp = 1'b0; hrdata = $urandom;
      end
      @(posedge hclk); #1;
      if (dpend && hready) dpend = 1'b0;
      else if (nonseq_now && hready) begin dpend = 1'b1; xfers++; end
    end
    exp_cyc = mis ? 0 : 2 + v.awaits + v.dwaits;
    exp_wen = (v.rd != 0 && !v.exp_err) ? 1 : 0;
    chk({v.name, " done cycle"}, done_cyc, exp_cyc);
    chk({v.name, " transfers"}, xfers, mis ? 0 : 1);
    chk({v.name, " err"}, {31'h0, err_seen}, {31'h0, v.exp_err});
    chk({v.name, " wen count"}, wen_cnt, exp_wen);
    if (!mis) begin
      chk({v.name, " haddr"}, haddr_seen, addr);
      chk({v.name, " hsize"}, {29'h0, hsize_seen}, {30'h0, v.size} - 32'd1);
    end
    if (exp_wen == 1) begin
      chk({v.name, " wdata"}, wdata_seen, v.exp_data);
      chk({v.name, " waddr"}, {27'h0, waddr_seen}, {27'h0, v.rd});
    end
    for (int c = 0; c < 2; c++) begin
      chk({v.name, " idle while en held"},
          {28'h0, mau_load_busy, mau_load_done, reg_wen_1, htrans[1]}, 32'h0);
      @(posedge hclk); #1;
    end
    $display("txn %s addr=%h size=%0d done_cycle=%0d err=%0b writes=%0d data=%h",
             v.name, addr, v.size, done_cyc, err_seen, wen_cnt, wdata_seen);
    exu_load_en = 1'b0;
    @(posedge hclk); #1;
  endtask

  vec_t vecs[8];
  vec_t rv;

  initial begin
    vecs[0] = '{"lw_basic", 32'h1000, 32'h4, 5'd5, 2'd3, 1'b0, 32'hDEADBEEF, 0, 0, 1'b0, 32'hDEADBEEF, 1'b0};
    vecs[1] = '{"lb_sext", 32'h2003, 32'h0, 5'd1, 2'd1, 1'b1, 32'h80112233, 0, 0, 1'b0, 32'hFFFFFF80, 1'b0};
    vecs[2] = '{"lbu", 32'h2003, 32'h0, 5'd2, 2'd1, 1'b0, 32'h80112233, 0, 0, 1'b0, 32'h00000080, 1'b0};
    vecs[3] = '{"lh_neg_off_waits", 32'h3000, 32'hFFFFFFFE, 5'd7, 2'd2, 1'b1, 32'h7FFF1234, 0, 2, 1'b0, 32'h00007FFF, 1'b0};
    vecs[4] = '{"lw_misaligned", 32'h4002, 32'h0, 5'd3, 2'd3, 1'b0, 32'h0, 0, 0, 1'b0, 32'h0, 1'b1};
    vecs[5] = '{"lh_misaligned", 32'h4001, 32'h0, 5'd3, 2'd2, 1'b1, 32'h0, 0, 0, 1'b0, 32'h0, 1'b1};
    vecs[6] = '{"lw_bus_error", 32'h5000, 32'h8, 5'd9, 2'd3, 1'b0, 32'h12345678, 1, 1, 1'b1, 32'h0, 1'b1};
    vecs[7] = '{"lw_rd0", 32'h6000, 32'h0, 5'd0, 2'd3, 1'b0, 32'hCAFEF00D, 0, 0, 1'b0, 32'hCAFEF00D, 1'b0};

    hrstn = 1'b0; exu_load_en = 1'b0; exu_load_rd = '0; exu_load_base_addr = '0;
    exu_load_offset = '0; exu_load_sext = 1'b0; exu_load_size = '0;
    hready = 1'b1; hresp = 1'b0; hrdata = '0;
    repeat (3) @(posedge hclk);
    #1;
    chk_reset_outputs("reset");
    hrstn = 1'b1;
    @(posedge hclk); #1;

    for (int i = 0; i < 8; i++) run_load(vecs[i]);

    // Size-0 request is a no-op.
    exu_load_en = 1'b1; exu_load_size = 2'd0; exu_load_base_addr = 32'h7000;
    for (int c = 0; c < 3; c++) begin
      @(posedge hclk); #1;
      chk("size0 ignored", {30'h0, mau_load_busy, htrans[1]}, 32'h0);
    end
    $display("txn size0 ignored busy=%0b", mau_load_busy);
    exu_load_en = 1'b0;
    @(posedge hclk); #1;

    // Reset asserted while the read is in its data phase.
    exu_load_en = 1'b1; exu_load_rd = 5'd11; exu_load_base_addr = 32'h8000;
    exu_load_offset = 32'h4; exu_load_size = 2'd3; exu_load_sext = 1'b0;
    hready = 1'b1; hresp = 1'b0;
    @(posedge hclk); #1;
    chk("rst_mid addr phase", {30'h0, htrans}, 32'h2);
    @(posedge hclk); #1;
    hready = 1'b0;
    #2 hrstn = 1'b0;
    #1 chk_reset_outputs("rst_mid");
    exu_load_en = 1'b0;
    @(posedge hclk); #1;
    chk("rst_mid no write", {31'h0, reg_wen_1}, 32'h0);
    hrstn = 1'b1;
    hready = 1'b1;
    $display("txn reset during data phase abandoned");
    @(posedge hclk); #1;
    rv = '{"after_reset", 32'h8000, 32'h4, 5'd11, 2'd3, 1'b0, 32'h0BADCAFE, 0, 0, 1'b0, 32'h0BADCAFE, 1'b0};
    run_load(rv);

    for (int i = 0; i < 20; i++) begin
      rv.name   = $sformatf("rand%0d", i);
      rv.size   = 2'($urandom_range(1, 3));
      rv.base   = $urandom;
      rv.off    = (($urandom % 2) == 0) ? 32'($urandom_range(0, 64)) : -32'($urandom_range(0, 64));
      rv.rd     = 5'($urandom);
      rv.sext   = 1'($urandom);
      rv.data   = $urandom;
      rv.awaits = $urandom_range(0, 2);
      rv.dwaits = $urandom_range(0, 2);
      rv.rerr   = ($urandom_range(0, 5) == 0);
      rv.exp_err  = rv.rerr || ref_misaligned(rv.base + rv.off, rv.size);
      rv.exp_data = ref_load(rv.base + rv.off, rv.size, rv.sext, rv.data);
      run_load(rv);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
